// File: rtl/ldvio_valid_ctrl.sv
// ==== ldvio_valid_ctrl: write-port arbiter for the load-violation valid RAM (sweep > clear > queued set) ====
// ==== Optional: LDVIO_VALID_CTRL_STATS_EN adds stall/cancel counters. Rev 1.0                         ====
`default_nettype none

module ldvio_valid_ctrl #(
  parameter int DEPTH  = 16,
  parameter int INDEX  = 4,
  parameter int WIDTH  = 8,
  parameter int QDEPTH = 4,
  parameter int QINDEX = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             set_valid_i,
  input  logic [INDEX-1:0] set_addr_i,
  input  logic [WIDTH-1:0] set_data_i,
  output logic             set_ready_o,
  input  logic             clr_valid_i,
  input  logic [INDEX-1:0] clr_addr_i,
  output logic             busy_o,
  output logic             we0_o,
  output logic [INDEX-1:0] addr0wr_o,
  output logic [WIDTH-1:0] data0wr_o
`ifdef LDVIO_VALID_CTRL_STATS_EN
  ,
  output logic [31:0]      stall_cnt_o,
  output logic [15:0]      cancel_cnt_o
`endif
);

  typedef enum logic [0:0] {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  localparam logic [INDEX-1:0]  LAST_PTR = INDEX'(DEPTH - 1);
  localparam logic [QINDEX:0]   FULL_CNT = (QINDEX + 1)'(QDEPTH);
  localparam logic [QINDEX:0]   CNT_ONE  = (QINDEX + 1)'(1);
  localparam logic [QINDEX-1:0] PTR_ONE  = QINDEX'(1);
  localparam logic [INDEX-1:0]  SWP_ONE  = INDEX'(1);

  state_t             state_q, state_d;
  logic [INDEX-1:0]   sweep_ptr_q, sweep_ptr_d;
  logic [INDEX-1:0]   fifo_addr_q [QDEPTH];
  logic [INDEX-1:0]   fifo_addr_d [QDEPTH];
  logic [WIDTH-1:0]   fifo_data_q [QDEPTH];
  logic [WIDTH-1:0]   fifo_data_d [QDEPTH];
  logic [QDEPTH-1:0]  fifo_vld_q, fifo_vld_d;
  logic [QINDEX-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [QINDEX:0]    count_q, count_d;

  logic               full, empty, push, pop, clr_acc;
  logic [QDEPTH-1:0]  cancel_hit;

  assign full        = (count_q == FULL_CNT);
  assign empty       = (count_q == '0);
  assign busy_o      = (state_q == SWEEP);
  assign set_ready_o = reset && !full && !busy_o && !flush_i;
  assign push        = set_valid_i && set_ready_o;

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < QDEPTH; i++) begin : g_cancel
    logic [QINDEX-1:0] off;
    assign off           = QINDEX'(i) - rptr_q;
    assign cancel_hit[i] = clr_acc && ({1'b0, off} < count_q) && fifo_vld_q[i]
                           && (fifo_addr_q[i] == clr_addr_i);
  end

  // Write-port arbitration; a flush cycle in IDLE writes nothing.
  always_comb begin
    we0_o     = 1'b0;
    addr0wr_o = '0;
    data0wr_o = '0;
    pop       = 1'b0;
    clr_acc   = 1'b0;
    if (!reset) begin
      we0_o = 1'b0;
    end else if (state_q == SWEEP) begin
      we0_o     = 1'b1;
      addr0wr_o = sweep_ptr_q;
    end else if (!flush_i) begin
      if (clr_valid_i) begin
        we0_o     = 1'b1;
        addr0wr_o = clr_addr_i;
        clr_acc   = 1'b1;
      end else if (!empty) begin
        pop = 1'b1;
        if (fifo_vld_q[rptr_q]) begin
          we0_o     = 1'b1;
          addr0wr_o = fifo_addr_q[rptr_q];
          data0wr_o = fifo_data_q[rptr_q];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_ptr_d = sweep_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d     = SWEEP;
          sweep_ptr_d = '0;
        end
      end
      SWEEP: begin
        if (flush_i) begin
          sweep_ptr_d = '0;
        end else if (sweep_ptr_q == LAST_PTR) begin
          state_d = IDLE;
        end else begin
          sweep_ptr_d = sweep_ptr_q + SWP_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    fifo_vld_d  = fifo_vld_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      // Cancel first so a set pushed alongside a matching clear survives.
      fifo_vld_d = fifo_vld_q & ~cancel_hit;
      if (push) begin
        fifo_addr_d[wptr_q] = set_addr_i;
        fifo_data_d[wptr_q] = set_data_i;
        fifo_vld_d[wptr_q]  = 1'b1;
        wptr_d              = wptr_q + PTR_ONE;
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sweep_ptr_q <= '0;
      fifo_vld_q  <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      sweep_ptr_q <= sweep_ptr_d;
      fifo_vld_q  <= fifo_vld_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
    end
  end

`ifdef LDVIO_VALID_CTRL_STATS_EN
  logic [31:0]     stall_cnt_q, stall_cnt_d;
  logic [15:0]     cancel_cnt_q, cancel_cnt_d;
  logic [QINDEX:0] cancel_n;
  logic [16:0]     cancel_sum;

  always_comb begin
    cancel_n = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      cancel_n = cancel_n + (QINDEX + 1)'(cancel_hit[i]);
    end
    cancel_sum   = {1'b0, cancel_cnt_q} + 17'(cancel_n);
    cancel_cnt_d = cancel_sum[16] ? 16'hFFFF : cancel_sum[15:0];
    stall_cnt_d  = stall_cnt_q;
    if (set_valid_i && !set_ready_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q  <= '0;
      cancel_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      cancel_cnt_q <= cancel_cnt_d;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign cancel_cnt_o = cancel_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ldvio_valid_ctrl.sv
// ==== tb_ldvio_valid_ctrl: scoreboard bench for ldvio_valid_ctrl. Rev 1.0 ====
`default_nettype none
`timescale 1ns/1ps

module tb_ldvio_valid_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush_i, set_valid_i, clr_valid_i;
  logic [3:0] set_addr_i, clr_addr_i;
  logic [7:0] set_data_i;
  logic       set_ready_o, busy_o, we0_o;
  logic [3:0] addr0wr_o;
  logic [7:0] data0wr_o;
`ifdef LDVIO_VALID_CTRL_STATS_EN
  logic [31:0] stall_cnt_o;
  logic [15:0] cancel_cnt_o;
`endif

  ldvio_valid_ctrl u_dut (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush_i),
    .set_valid_i (set_valid_i),
    .set_addr_i  (set_addr_i),
    .set_data_i  (set_data_i),
    .set_ready_o (set_ready_o),
    .clr_valid_i (clr_valid_i),
    .clr_addr_i  (clr_addr_i),
    .busy_o      (busy_o),
    .we0_o       (we0_o),
    .addr0wr_o   (addr0wr_o),
    .data0wr_o   (data0wr_o)
`ifdef LDVIO_VALID_CTRL_STATS_EN
    ,
    .stall_cnt_o (stall_cnt_o),
    .cancel_cnt_o(cancel_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic exp_wr(input logic [3:0] a, input logic [7:0] d);
    exp_q.push_back('{a: a, d: d});
  endtask

  task automatic drv(input logic fl, input logic sv, input logic [3:0] sa, input logic [7:0] sd,
                     input logic cv, input logic [3:0] ca);
    flush_i     = fl;
    set_valid_i = sv;
    set_addr_i  = sa;
    set_data_i  = sd;
    clr_valid_i = cv;
    clr_addr_i  = ca;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every RAM write must match the next expected write, in order.
  always @(negedge clk) begin
    if (reset === 1'b1 && we0_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_write_addr", {28'd0, addr0wr_o}, 32'hDEAD);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check_val("sb_addr", {28'd0, addr0wr_o}, {28'd0, e.a});
        check_val("sb_data", {24'd0, data0wr_o}, {24'd0, e.d});
      end
    end
  end

  initial begin
    reset = 1'b0;
    // Live requests during reset must not reach the write port.
    drv(1'b0, 1'b1, 4'd2, 8'h33, 1'b1, 4'd5);
    #2;
    check_val("rst_ready", {31'd0, set_ready_o}, 32'd0);
    check_val("rst_we", {31'd0, we0_o}, 32'd0);
    check_val("rst_busy", {31'd0, busy_o}, 32'd0);
    check_val("rst_addr", {28'd0, addr0wr_o}, 32'd0);
    check_val("rst_data", {24'd0, data0wr_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Set then drain
    drv(1'b0, 1'b1, 4'd3, 8'h01, 1'b0, 4'd0);
    exp_wr(4'd3, 8'h01);
    @(negedge clk);
    check_val("t1_ready_c1", {31'd0, set_ready_o}, 32'd1);
    check_val("t1_no_bypass", {31'd0, we0_o}, 32'd0);
    step();
    drv(1'b0, 1'b1, 4'd5, 8'h01, 1'b0, 4'd0);
    exp_wr(4'd5, 8'h01);
    @(negedge clk);
    check_val("t1_ready_c2", {31'd0, set_ready_o}, 32'd1);
    check_val("t1_we_c2", {31'd0, we0_o}, 32'd1);
    check_val("t1_addr_c2", {28'd0, addr0wr_o}, 32'd3);
    step();
    idle();
    @(negedge clk);
    check_val("t1_we_c3", {31'd0, we0_o}, 32'd1);
    check_val("t1_addr_c3", {28'd0, addr0wr_o}, 32'd5);
    step();
    @(negedge clk);
    check_val("t1_idle_c4", {31'd0, we0_o}, 32'd0);
    step();

    // Clear priority: clears own the port while sets queue behind them
    drv(1'b0, 1'b1, 4'd1, 8'h11, 1'b1, 4'd8);
    exp_wr(4'd8, 8'h00);
    step();
    drv(1'b0, 1'b1, 4'd2, 8'h22, 1'b1, 4'd10);
    exp_wr(4'd10, 8'h00);
    step();
    drv(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd9);
    exp_wr(4'd9, 8'h00);
    exp_wr(4'd1, 8'h11);
    exp_wr(4'd2, 8'h22);
    @(negedge clk);
    check_val("t2_clr_addr", {28'd0, addr0wr_o}, 32'd9);
    step();
    idle();
    @(negedge clk);
    check_val("t2_set1_addr", {28'd0, addr0wr_o}, 32'd1);
    step();
    @(negedge clk);
    check_val("t2_set2_addr", {28'd0, addr0wr_o}, 32'd2);
    step();
    step();

    // Clear cancels a queued set
    drv(1'b0, 1'b1, 4'd4, 8'h44, 1'b1, 4'd12);
    exp_wr(4'd12, 8'h00);
    step();
    drv(1'b0, 1'b1, 4'd7, 8'h77, 1'b1, 4'd13);
    exp_wr(4'd13, 8'h00);
    step();
    drv(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd7);
    exp_wr(4'd7, 8'h00);
    exp_wr(4'd4, 8'h44);
    step();
    idle();
    @(negedge clk);
    check_val("t3_set4_addr", {28'd0, addr0wr_o}, 32'd4);
    step();
    @(negedge clk);
    check_val("t3_cancelled_we", {31'd0, we0_o}, 32'd0);
    step();
    step();
`ifdef LDVIO_VALID_CTRL_STATS_EN
    check_val("t3_cancel_cnt", {16'd0, cancel_cnt_o}, 32'd1);
`endif

    // FIFO full: clears hold the port while five sets arrive
    for (int k = 0; k < 5; k++) begin
      drv(1'b0, 1'b1, 4'(k), 8'(8'h50 + k), 1'b1, 4'(8 + k));
      exp_wr(4'(8 + k), 8'h00);
      @(negedge clk);
      check_val("t4_ready", {31'd0, set_ready_o}, (k < 4) ? 32'd1 : 32'd0);
      step();
    end
    for (int k = 0; k < 5; k++) exp_wr(4'(k), 8'(8'h50 + k));
    drv(1'b0, 1'b1, 4'd4, 8'h54, 1'b0, 4'd0);
    @(negedge clk);
    check_val("t4_ready_pop", {31'd0, set_ready_o}, 32'd0);
    step();
    @(negedge clk);
    check_val("t4_ready_free", {31'd0, set_ready_o}, 32'd1);
    step();
    idle();
    repeat (4) step();
`ifdef LDVIO_VALID_CTRL_STATS_EN
    check_val("t4_stall_cnt", stall_cnt_o, 32'd2);
`endif
    check_val("t4_sb_drained", exp_q.size(), 32'd0);

    // Flush sweep with two queued sets that must never be written
    drv(1'b0, 1'b1, 4'd10, 8'hAA, 1'b1, 4'd14);
    exp_wr(4'd14, 8'h00);
    step();
    drv(1'b0, 1'b1, 4'd11, 8'hBB, 1'b1, 4'd15);
    exp_wr(4'd15, 8'h00);
    step();
    drv(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    for (int k = 0; k < 16; k++) exp_wr(4'(k), 8'h00);
    @(negedge clk);
    check_val("t5_flush_we", {31'd0, we0_o}, 32'd0);
    check_val("t5_flush_ready", {31'd0, set_ready_o}, 32'd0);
    step();
    idle();
    for (int k = 0; k < 16; k++) begin
      if (k == 4) drv(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
      else idle();
      @(negedge clk);
      check_val("t5_busy", {31'd0, busy_o}, 32'd1);
      check_val("t5_we", {31'd0, we0_o}, 32'd1);
      check_val("t5_addr", {28'd0, addr0wr_o}, k);
      check_val("t5_ready", {31'd0, set_ready_o}, 32'd0);
      step();
    end
    idle();
    @(negedge clk);
    check_val("t5_done_busy", {31'd0, busy_o}, 32'd0);
    check_val("t5_done_we", {31'd0, we0_o}, 32'd0);
    step();
    @(negedge clk);
    check_val("t5_fifo_empty_we", {31'd0, we0_o}, 32'd0);
    step();

    // Flush restart at sweep_ptr 6, then async reset at sweep_ptr 10
    drv(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    for (int k = 0; k <= 6; k++) exp_wr(4'(k), 8'h00);
    step();
    idle();
    repeat (6) step();
    drv(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    for (int k = 0; k <= 10; k++) exp_wr(4'(k), 8'h00);
    @(negedge clk);
    check_val("t6_addr_at_reflush", {28'd0, addr0wr_o}, 32'd6);
    step();
    idle();
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      check_val("t6_restart_addr", {28'd0, addr0wr_o}, k);
      if (k < 10) step();
    end
    #1;
    reset = 1'b0;
    #1;
    check_val("t6_rst_we", {31'd0, we0_o}, 32'd0);
    check_val("t6_rst_busy", {31'd0, busy_o}, 32'd0);
    check_val("t6_rst_ready", {31'd0, set_ready_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_val("t6_post_busy", {31'd0, busy_o}, 32'd0);
    check_val("t6_post_we", {31'd0, we0_o}, 32'd0);
    check_val("t6_post_ready", {31'd0, set_ready_o}, 32'd1);
    check_val("sb_empty_end", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ldvio_valid_ctrl.md
Name: ldvio_valid_ctrl

Overview:
- Controller for the single write port of the load-violation valid RAM (DEPTH entries, one per load-queue slot).
- Arbitrates three write sources onto that one port:
  - a queued stream of "set" requests from violation detection;
  - direct "clear" requests from retire;
  - a flush sweep that zeroes every entry one per cycle, because the RAM has only one write port and no bulk clear.
- The dispatch-side read ports bypass this block.

Parameters:
- DEPTH, 16, number of RAM entries.
- INDEX, 4, RAM address width; must satisfy 2^INDEX >= DEPTH.
- WIDTH, 8, RAM data width.
- QDEPTH, 4, set-request FIFO depth; power of two, at least 2.
- QINDEX, 2, log2(QDEPTH).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush_i  in  1  pipeline flush; starts a clear sweep.
- set_valid_i  in  1  set request valid.
- set_addr_i  in  INDEX  entry to set.
- set_data_i  in  WIDTH  value to write.
- set_ready_o  out  1  FIFO can accept a set this cycle.
- clr_valid_i  in  1  clear request; no backpressure.
- clr_addr_i  in  INDEX  entry to clear (write 0).
- busy_o  out  1  sweep in progress.
- we0_o  out  1  RAM write enable.
- addr0wr_o  out  INDEX  RAM write address.
- data0wr_o  out  WIDTH  RAM write data.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty; state IDLE; sweep_ptr=0.
  - Outputs: we0_o=0, addr0wr_o=0, data0wr_o=0, busy_o=0.
  - set_ready_o=0 while reset is asserted; it is 1 in the first cycle after release.
- Write-port outputs are combinational from current state, FIFO head, clr_valid_i and clr_addr_i. The RAM updates at the next edge.
- States: IDLE, SWEEP.
- Transitions:
  - IDLE -> SWEEP on flush_i.
  - SWEEP -> IDLE after the write with sweep_ptr==DEPTH-1.
  - flush_i in SWEEP resets sweep_ptr to 0; the sweep restarts.
- Write-port priority, one write per cycle:
  - SWEEP: we0_o=1, addr0wr_o=sweep_ptr, data0wr_o=0. sweep_ptr increments and stops at DEPTH-1, never wrapping.
  - IDLE with clr_valid_i: write 0 to clr_addr_i.
  - IDLE with FIFO non-empty: write the head entry and pop it.
  - Otherwise we0_o=0.
- FIFO:
  - Enqueue when set_valid_i && set_ready_o.
  - set_ready_o = !full && !busy_o && !flush_i.
  - No same-cycle bypass: a set enqueued in cycle N writes no earlier than N+1.
  - Pointers wrap modulo QDEPTH; a count register of QINDEX+1 bits distinguishes full from empty.
  - Simultaneous push and pop when full is not possible (ready is low); push and pop when non-full are both performed.
- Clear cancels queued sets:
  - An accepted clear invalidates every queued FIFO entry whose address equals clr_addr_i.
  - Invalidated entries still occupy their slot; when they reach the head they pop with we0_o=0 and cost one cycle.
  - A set enqueued in the same cycle as a matching clear is not cancelled.
- Flush:
  - flush_i empties the FIFO at that edge; count becomes 0.
  - Clears and sets presented in the flush cycle are dropped.
  - clr_valid_i is ignored during SWEEP.
- busy_o=1 from the cycle after flush_i through the final sweep write (DEPTH cycles).
- Reset asserted mid-sweep aborts the sweep immediately; entries not yet written keep their values. The RAM's own reset clears them.

Optional Feature:
- Macro LDVIO_VALID_CTRL_STATS_EN.
- Defined: adds outputs stall_cnt_o[31:0] and cancel_cnt_o[15:0].
  - stall_cnt_o counts cycles with set_valid_i && !set_ready_o.
  - cancel_cnt_o counts FIFO entries invalidated by clears.
  - Both saturate at their maximum value and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Set then drain:
  - Stimulus: reset release; cycle 1 set addr=3 data=0x01; cycle 2 set addr=5 data=0x01.
  - Response: we0_o=1 at addr 3 in cycle 2 and at addr 5 in cycle 3, both data 0x01; set_ready_o stays 1.
- Clear priority:
  - Stimulus: 2 queued sets (addr 1, 2); clr_valid_i with addr 9 in the same cycle.
  - Response: that cycle writes addr 9 data 0; the sets write on the following 2 cycles.
- Clear cancels a queued set:
  - Stimulus: queue set addr 7 behind set addr 4; clear addr 7 while both are queued.
  - Response: addr 4 written; the addr 7 slot pops with we0_o=0; cancel_cnt_o=1 with the feature enabled.
- FIFO full:
  - Stimulus: QDEPTH=4; hold clr_valid_i high and present 5 consecutive sets.
  - Response: set_ready_o=0 after 4 accepts; the 5th is held; stall_cnt_o increments each stalled cycle.
- Flush sweep:
  - Stimulus: 2 sets queued; pulse flush_i in cycle N.
  - Response: FIFO empty at N+1; busy_o=1 and we0_o=1 at addr 0..15, data 0, in cycles N+1..N+16; busy_o=0 at N+17; the queued sets are never written.
- Flush restart and async reset:
  - Stimulus: flush_i again at sweep_ptr=6; later, assert reset at sweep_ptr=10.
  - Response: sweep restarts at addr 0 the next cycle; on reset, we0_o=0 and busy_o=0 immediately, without waiting for a clock edge.
